qbus_ram_bridge: RTL and testbench
==================================

QBUS_RAM_BRIDGE -- requirements
Module: qbus_ram_bridge

Interface
REQ-001 Parameter RAM_TOP, 16'o160000: exclusive upper byte address of the RAM window; addresses >= RAM_TOP get no reply.
REQ-002 Parameter WAIT_STATES, 0: extra ce-cycles (0..15) inserted between mem_ready and RPLY.
REQ-003 Parameter BUS_TIMEOUT, 63: ce-cycles from transaction start to error_o.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ce  in  1  clock enable; state advances only when ce=1.
REQ-007 addr_i  in  16  CPU address bus (addr_o of vm1).
REQ-008 data_i  in  16  CPU write data (data_o of vm1), byte already in its lane.
REQ-009 data_o  out  16  read data to CPU (data_i of vm1).
REQ-010 SYNC, DIN, DOUT, WTBT  in  1 each  bus strobes from vm1.
REQ-011 RPLY  out  1  reply to vm1.
REQ-012 error_o  out  1  one-ce-cycle bus-timeout pulse to vm1 error_i.
REQ-013 mem_req  out  1  memory request, held until mem_ready or abort.
REQ-014 mem_we  out  1  1=write, 0=read; valid with mem_req.
REQ-015 mem_addr  out  15  word address = latched addr_i[15:1].
REQ-016 mem_be  out  2  byte enables; mem_wdata  out  16; mem_rdata  in  16; mem_ready  in  1.

Function
REQ-017 States: IDLE, MEM, WAITST, REPLY, NOREPLY, ERROR.
REQ-018 IDLE: on ce with SYNC&(DIN|DOUT): latch addr_i, data_i, WTBT, DOUT; go MEM if addr_i<RAM_TOP, else NOREPLY; timeout counter loads BUS_TIMEOUT.
REQ-019 MEM: mem_req=1; mem_we=latched DOUT; on mem_ready: read latches mem_rdata into data_o; go WAITST if WAIT_STATES>0, else REPLY.
REQ-020 WAITST: count down WAIT_STATES ce-cycles, then REPLY.
REQ-021 REPLY: RPLY=1, data_o stable; on DIN|DOUT low go IDLE, RPLY deasserted that edge.
REQ-022 Byte write (DOUT&WTBT): mem_be=01 if addr[0]=0, 10 if addr[0]=1; word access: mem_be=11, addr[0] ignored; reads always mem_be=11.
REQ-023 Latency (WAIT_STATES=0, mem_ready first MEM cycle): request seen cycle 0, mem_req cycle 1, RPLY cycle 2.
REQ-024 Timeout counter decrements every ce-cycle outside IDLE/REPLY; reaching 0 in MEM, WAITST or NOREPLY -> ERROR: error_o=1 one ce-cycle, mem_req dropped, RPLY never asserted.
REQ-025 ERROR waits for SYNC=0, then IDLE.
REQ-026 Abort: SYNC low in any non-IDLE state -> IDLE next ce edge; mem_req/RPLY low; late mem_ready ignored.
REQ-027 mem_ready outside MEM is ignored; DIN and DOUT both high is treated as read.
REQ-028 ce=0: all outputs and state hold.

Reset
REQ-029 reset=1 (regardless of ce) -> IDLE; RPLY, error_o, mem_req, mem_we = 0; mem_be=00; mem_addr, mem_wdata, data_o = 0; counters cleared; mid-transaction reset drops everything the next edge.

Structure
REQ-030 State encodings and default BUS_TIMEOUT/RAM_TOP live in the shared include "qbus.h".
REQ-031 Timeout counter is one sub-module, bus_watchdog (load, enable, expired).

Verification
REQ-032 Word read 16'o001000, mem_rdata=16'o012345, mem_ready 1st MEM cycle -> mem_addr=15'o000400, RPLY cycle 2, data_o=16'o012345.
REQ-033 Byte write 16'o001001, WTBT=1, data_i=16'h5A00 -> mem_we=1, mem_be=2'b10, mem_wdata=16'h5A00, then RPLY.
REQ-034 Read 16'o177716 (>=RAM_TOP), BUS_TIMEOUT=63 -> no mem_req, no RPLY, error_o one pulse 63 ce-cycles later.
REQ-035 SYNC drops while MEM waits -> mem_req low next edge; later mem_ready gives no RPLY.
REQ-036 WAIT_STATES=3 with ce toggling 1/0 -> RPLY after exactly 3 enabled cycles past mem_ready.
REQ-037 reset asserted during REPLY -> RPLY=0, data_o=0 next edge; next transaction completes normally.

Source files
------------

// File: rtl/qbus_ram_bridge_pkg.sv
// Shared definitions for the Q-bus to synchronous-RAM bridge: FSM state
// encodings, default window/timeout values and the byte-lane helper.
`timescale 1ns/1ps

package qbus_ram_bridge_pkg;

  // Bridge FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MEM     = 3'd1,
    ST_WAITST  = 3'd2,
    ST_REPLY   = 3'd3,
    ST_NOREPLY = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  // Exclusive upper byte address of the RAM window (I/O page starts here)
  localparam logic [15:0] DEF_RAM_TOP = 16'o160000;

  // ce-cycles from the start of a bus cycle until the timeout fires
  localparam int DEF_BUS_TIMEOUT = 63;

  // Extra ce-cycles between mem_ready and RPLY
  localparam int DEF_WAIT_STATES = 0;

  // Width of the watchdog down-counter
  localparam int WD_W = 16;

  // Width of the wait-state down-counter (covers 0..15)
  localparam int WS_W = 4;

  // Byte enables for a Q-bus access. Only a byte write narrows the lanes;
  // the CPU already placed the byte in its lane, so addr[0] picks the lane.
  function automatic logic [1:0] byte_enables(input logic write,
                                              input logic byte_op,
                                              input logic addr_lsb);
    logic [1:0] be;
    be = 2'b11;
    if (write && byte_op) begin
      be = addr_lsb ? 2'b10 : 2'b01;
    end
    return be;
  endfunction

endpackage : qbus_ram_bridge_pkg

// File: rtl/qbus_ram_bridge_watchdog.sv
// Bus-cycle watchdog: loads a timeout on the first cycle of a transaction
// and counts down on enabled cycles. `expired` is high on the cycle whose
// decrement would take the count to zero, so the FSM leaves on that edge.
`timescale 1ns/1ps

module bus_watchdog
  import qbus_ram_bridge_pkg::*;
#(
  parameter int TIMEOUT = DEF_BUS_TIMEOUT,
  parameter int W       = WD_W
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  logic [W-1:0] count;

  // Load on transaction start, otherwise count down while enabled
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= W'(TIMEOUT);
    end else if (enable && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  // Fires on the enabled cycle that reaches zero (or if already empty)
  assign expired = enable && (count <= W'(1));

endmodule : bus_watchdog

// File: rtl/qbus_ram_bridge.sv
// Q-bus slave bridge between the vm1 CPU strobes (SYNC/DIN/DOUT/WTBT/RPLY)
// and a simple request/ready synchronous RAM port. Addresses below RAM_TOP
// are forwarded to RAM; anything above is left unanswered so the bus
// watchdog raises error_o. All state advances only on ce=1 edges.
`timescale 1ns/1ps

module qbus_ram_bridge
  import qbus_ram_bridge_pkg::*;
#(
  parameter logic [15:0] RAM_TOP     = DEF_RAM_TOP,
  parameter int          WAIT_STATES = DEF_WAIT_STATES,
  parameter int          BUS_TIMEOUT = DEF_BUS_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] addr_i,
  input  logic [15:0] data_i,
  output logic [15:0] data_o,
  input  logic        SYNC,
  input  logic        DIN,
  input  logic        DOUT,
  input  logic        WTBT,
  output logic        RPLY,
  output logic        error_o,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready
);

  state_t          state;
  logic [WS_W-1:0] ws_cnt;
  logic            strobe;
  logic            bus_start;
  logic            is_write;
  logic            wd_load;
  logic            wd_en;
  logic            wd_expired;

  // Either data strobe; DIN and DOUT together count as a read
  assign strobe    = DIN | DOUT;
  assign bus_start = SYNC & strobe;
  assign is_write  = DOUT & ~DIN;

  // Watchdog runs only while the bridge is waiting on something
  assign wd_load = ce & (state == ST_IDLE) & bus_start;
  assign wd_en   = ce & ((state == ST_MEM) | (state == ST_WAITST) | (state == ST_NOREPLY));

  bus_watchdog #(
    .TIMEOUT (BUS_TIMEOUT),
    .W       (WD_W)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .load    (wd_load),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  // Bridge FSM with registered bus and memory-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ws_cnt    <= '0;
      RPLY      <= 1'b0;
      error_o   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 2'b00;
      mem_wdata <= '0;
      data_o    <= '0;
    end else if (ce) begin
      // error_o is a single ce-cycle pulse unless re-armed below
      error_o <= 1'b0;

      case (state)
        ST_IDLE: begin
          RPLY    <= 1'b0;
          mem_req <= 1'b0;
          if (bus_start) begin
            mem_addr  <= addr_i[15:1];
            mem_wdata <= data_i;
            mem_we    <= is_write;
            mem_be    <= byte_enables(is_write, WTBT, addr_i[0]);
            if (addr_i < RAM_TOP) begin
              state   <= ST_MEM;
              mem_req <= 1'b1;
            end else begin
              state <= ST_NOREPLY;
            end
          end
        end

        ST_MEM: begin
          if (!SYNC) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
          end else if (wd_expired) begin
            state   <= ST_ERROR;
            mem_req <= 1'b0;
            error_o <= 1'b1;
          end else if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              data_o <= mem_rdata;
            end
            if (WAIT_STATES > 0) begin
              state  <= ST_WAITST;
              ws_cnt <= WS_W'(WAIT_STATES);
            end else begin
              state <= ST_REPLY;
              RPLY  <= 1'b1;
            end
          end
        end

        ST_WAITST: begin
          if (!SYNC) begin
            state  <= ST_IDLE;
            ws_cnt <= '0;
          end else if (wd_expired) begin
            state   <= ST_ERROR;
            error_o <= 1'b1;
            ws_cnt  <= '0;
          end else if (ws_cnt <= WS_W'(1)) begin
            state  <= ST_REPLY;
            RPLY   <= 1'b1;
            ws_cnt <= '0;
          end else begin
            ws_cnt <= ws_cnt - WS_W'(1);
          end
        end

        ST_REPLY: begin
          // Hold RPLY and data_o until the CPU removes its strobe
          if (!SYNC || !strobe) begin
            state <= ST_IDLE;
            RPLY  <= 1'b0;
          end
        end

        ST_NOREPLY: begin
          // Nothing answers here; leave on abort or let the watchdog fire
          if (!SYNC) begin
            state <= ST_IDLE;
          end else if (wd_expired) begin
            state   <= ST_ERROR;
            error_o <= 1'b1;
          end
        end

        ST_ERROR: begin
          if (!SYNC) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state   <= ST_IDLE;
          RPLY    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule : qbus_ram_bridge

// File: tb/tb_qbus_ram_bridge.sv
// Scoreboard bench for qbus_ram_bridge. Stimulus pushes the expected bus
// response (RPLY with read data, or an error_o pulse) together with the
// enabled-cycle count at which it must appear; a monitor pops and compares
// whenever a DUT raises RPLY or error_o.
`timescale 1ns/1ps

module tb_qbus_ram_bridge;

  localparam int K_RPLY = 0;
  localparam int K_ERR  = 1;

  typedef struct {
    int          dev;
    int          kind;
    logic [15:0] data;
    int          cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce0 = 1'b0;
  logic        ce3 = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        SYNC = 1'b0;
  logic        DIN = 1'b0;
  logic        DOUT = 1'b0;
  logic        WTBT = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  logic [15:0] data_o0, data_o3;
  logic        rply0, rply3, err0, err3, mem_req0, mem_req3, mem_we0, mem_we3;
  logic [14:0] mem_addr0, mem_addr3;
  logic [1:0]  mem_be0, mem_be3;
  logic [15:0] mem_wdata0, mem_wdata3;

  int  total = 0;
  int  bad = 0;
  int  ce_cnt0 = 0;
  int  ce_cnt3 = 0;
  ev_t q[$];
  logic rply0_q = 1'b0, rply3_q = 1'b0, err0_q = 1'b0, err3_q = 1'b0;
  logic mreq_seen0 = 1'b0;

  always #5 clk = ~clk;

  qbus_ram_bridge #(.RAM_TOP(16'o160000), .WAIT_STATES(0), .BUS_TIMEOUT(63)) dut0 (
    .clk(clk), .reset(reset), .ce(ce0), .addr_i(addr), .data_i(wdata), .data_o(data_o0),
    .SYNC(SYNC), .DIN(DIN), .DOUT(DOUT), .WTBT(WTBT), .RPLY(rply0), .error_o(err0),
    .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_be(mem_be0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  qbus_ram_bridge #(.RAM_TOP(16'o160000), .WAIT_STATES(3), .BUS_TIMEOUT(63)) dut3 (
    .clk(clk), .reset(reset), .ce(ce3), .addr_i(addr), .data_i(wdata), .data_o(data_o3),
    .SYNC(SYNC), .DIN(DIN), .DOUT(DOUT), .WTBT(WTBT), .RPLY(rply3), .error_o(err3),
    .mem_req(mem_req3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_be(mem_be3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Enabled-edge counters, one per DUT clock enable
  always @(posedge clk) begin
    if (ce0) ce_cnt0 <= ce_cnt0 + 1;
    if (ce3) ce_cnt3 <= ce_cnt3 + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int dev, input int kind, input logic [15:0] data, input int cyc);
    ev_t e;
    e.dev  = dev;
    e.kind = kind;
    e.data = data;
    e.cyc  = cyc;
    q.push_back(e);
  endtask

  task automatic observe(input int dev, input int kind, input logic [15:0] data, input int cyc);
    ev_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: dev=%0d kind=%0d at ce_cycle=%0d, expected no event", dev, kind, cyc);
    end else begin
      e = q.pop_front();
      check("event_dev", dev, e.dev);
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.cyc);
      if (e.kind == K_RPLY) check("event_data", {16'h0, data}, {16'h0, e.data});
    end
  endtask

  // Monitor: compare every RPLY / error_o rising edge against the scoreboard
  always @(negedge clk) begin
    if (rply0 && !rply0_q) observe(0, K_RPLY, data_o0, ce_cnt0);
    if (err0 && !err0_q)   observe(0, K_ERR, 16'h0, ce_cnt0);
    if (rply3 && !rply3_q) observe(3, K_RPLY, data_o3, ce_cnt3);
    if (err3 && !err3_q)   observe(3, K_ERR, 16'h0, ce_cnt3);
    if (mem_req0) mreq_seen0 = 1'b1;
    rply0_q = rply0;
    rply3_q = rply3;
    err0_q  = err0;
    err3_q  = err3;
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    #1;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("event_arrival_within_budget", q.size(), 0);
  endtask

  // Start a dev0 RAM access, answer it in the first MEM cycle, wait for RPLY
  task automatic xfer_begin(input logic [15:0] a, input logic [15:0] d, input logic din,
                            input logic dout, input logic wtbt, input logic [15:0] rdata,
                            input logic [14:0] exp_addr, input logic exp_we,
                            input logic [1:0] exp_be, input logic [15:0] exp_data);
    int base;
    @(negedge clk);
    base = ce_cnt0;
    addr = a; wdata = d; DIN = din; DOUT = dout; WTBT = wtbt; SYNC = 1'b1; mem_ready = 1'b0;
    expect_ev(0, K_RPLY, exp_data, base + 2);
    @(negedge clk);
    check("mem_req_asserted", mem_req0, 1);
    check("mem_addr", mem_addr0, exp_addr);
    check("mem_we", mem_we0, exp_we);
    check("mem_be", mem_be0, exp_be);
    if (exp_we) check("mem_wdata", mem_wdata0, d);
    mem_rdata = rdata;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("mem_req_released", mem_req0, 0);
    wait_drain(20);
    check("rply_held", rply0, 1);
  endtask

  task automatic xfer_end();
    @(negedge clk);
    DIN = 1'b0; DOUT = 1'b0;
    @(negedge clk);
    check("rply_released", rply0, 0);
    SYNC = 1'b0; WTBT = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench timeout");
  end

  initial begin
    int base;

    // Reset with ce low still clears every output
    reset = 1'b1; ce0 = 1'b0; ce3 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rply", rply0, 0);
    check("rst_error", err0, 0);
    check("rst_mem_req", mem_req0, 0);
    check("rst_mem_we", mem_we0, 0);
    check("rst_mem_be", mem_be0, 2'b00);
    check("rst_mem_addr", mem_addr0, 0);
    check("rst_mem_wdata", mem_wdata0, 0);
    check("rst_data_o", data_o0, 0);
    check("rst_dev3_rply", rply3, 0);
    check("rst_dev3_data_o", data_o3, 0);
    reset = 1'b0;
    ce0 = 1'b1;
    @(negedge clk);

    // Word read 16'o001000 -> RAM word 15'o000400, RPLY on cycle 2
    xfer_begin(16'o001000, 16'h0000, 1, 0, 0, 16'o012345, 15'o000400, 0, 2'b11, 16'o012345);
    xfer_end();
    // Byte write, odd address -> upper lane; data_o keeps last read value
    xfer_begin(16'o001001, 16'h5A00, 0, 1, 1, 16'hFFFF, 15'o000400, 1, 2'b10, 16'o012345);
    xfer_end();
    // Byte write, even address -> lower lane
    xfer_begin(16'o002000, 16'h00A5, 0, 1, 1, 16'hFFFF, 15'o001000, 1, 2'b01, 16'o012345);
    xfer_end();
    // Word write at odd address: addr[0] ignored, both lanes
    xfer_begin(16'o002003, 16'h1234, 0, 1, 0, 16'hFFFF, 15'o001001, 1, 2'b11, 16'o012345);
    xfer_end();
    // Last word below RAM_TOP with DIN and DOUT both high -> read
    xfer_begin(16'o157776, 16'h9999, 1, 1, 0, 16'hBEEF, 15'o067777, 0, 2'b11, 16'hBEEF);
    xfer_end();
    // Byte read: byte flag does not narrow a read
    xfer_begin(16'o000011, 16'h0000, 1, 0, 1, 16'hC0DE, 15'o000004, 0, 2'b11, 16'hC0DE);
    xfer_end();

    // Read in the I/O page: no mem_req, no RPLY, error after 63 ce-cycles
    @(negedge clk);
    base = ce_cnt0;
    mreq_seen0 = 1'b0;
    addr = 16'o177716; DIN = 1'b1; DOUT = 1'b0; WTBT = 1'b0; SYNC = 1'b1;
    expect_ev(0, K_ERR, 16'h0, base + 64);
    wait_drain(80);
    @(negedge clk);
    #1;
    check("error_pulse_one_cycle", err0, 0);
    check("noreply_no_mem_req", mreq_seen0, 0);
    check("noreply_no_rply", rply0, 0);
    SYNC = 1'b0; DIN = 1'b0;
    @(negedge clk);

    // Abort while MEM waits: mem_req drops next edge, late mem_ready ignored
    @(negedge clk);
    addr = 16'o000100; DIN = 1'b1; SYNC = 1'b1;
    @(negedge clk);
    check("abort_mem_req_before", mem_req0, 1);
    SYNC = 1'b0; DIN = 1'b0;
    @(negedge clk);
    check("abort_mem_req_after", mem_req0, 0);
    mem_rdata = 16'h1111; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
    check("abort_no_rply", rply0, 0);
    check("abort_data_o_kept", data_o0, 16'hC0DE);

    // WAIT_STATES=3 with ce toggling: RPLY exactly 3 enabled edges after mem_ready
    ce0 = 1'b0;
    @(negedge clk);
    base = ce_cnt3;
    ce3 = 1'b1;
    addr = 16'o000200; DIN = 1'b1; DOUT = 1'b0; WTBT = 1'b0; SYNC = 1'b1; mem_ready = 1'b0;
    expect_ev(3, K_RPLY, 16'h7777, base + 5);
    @(negedge clk);
    ce3 = 1'b0;
    mem_rdata = 16'h7777;
    check("ws_mem_req", mem_req3, 1);
    @(negedge clk);
    ce3 = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    ce3 = 1'b0; mem_ready = 1'b0;
    check("ws_mem_req_released", mem_req3, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ce3 = ~ce3;
    end
    wait_drain(4);
    @(negedge clk);
    ce3 = 1'b1; DIN = 1'b0;
    @(negedge clk);
    check("ws_rply_released", rply3, 0);
    SYNC = 1'b0; ce3 = 1'b0; ce0 = 1'b1;
    @(negedge clk);

    // Reset during REPLY clears RPLY and data_o, next access completes
    xfer_begin(16'o000300, 16'h0000, 1, 0, 0, 16'h4321, 15'o000140, 0, 2'b11, 16'h4321);
    @(negedge clk);
    reset = 1'b1; SYNC = 1'b0; DIN = 1'b0; DOUT = 1'b0;
    @(negedge clk);
    check("reset_reply_rply", rply0, 0);
    check("reset_reply_data_o", data_o0, 0);
    check("reset_reply_mem_be", mem_be0, 2'b00);
    reset = 1'b0;
    @(negedge clk);
    xfer_begin(16'o000400, 16'h0000, 1, 0, 0, 16'h2468, 15'o000200, 0, 2'b11, 16'h2468);
    xfer_end();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_qbus_ram_bridge
